// File: rtl/ssd_mux_display_if.sv
// ssd_mux_display_if
//   Bundles the control and pin-side signals of ssd_mux_display.
//   master: drives en/load/disp_val (and bright); samples busy/ovf/anode/seg_out.
//   slave : the display driver itself.
//   Optional: SSD_BRIGHTNESS_EN adds bright[3:0].
//   Signals:
//     en        display enable
//     load      one-cycle capture strobe for disp_val
//     disp_val  unsigned binary value, VAL_W bits
//     busy      conversion in progress
//     ovf       displayed value out of range
//     anode     active-low digit select, NUM_DIGITS bits
//     seg_out   active-low segments {g,f,e,d,c,b,a}
interface ssd_mux_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int VAL_W      = 14
);
    logic                  en;
    logic                  load;
    logic [VAL_W-1:0]      disp_val;
    logic                  busy;
    logic                  ovf;
    logic [NUM_DIGITS-1:0] anode;
    logic [6:0]            seg_out;
`ifdef SSD_BRIGHTNESS_EN
    logic [3:0]            bright;

    modport master (output en, load, disp_val, bright,
                    input  busy, ovf, anode, seg_out);
    modport slave  (input  en, load, disp_val, bright,
                    output busy, ovf, anode, seg_out);
`else
    modport master (output en, load, disp_val,
                    input  busy, ovf, anode, seg_out);
    modport slave  (input  en, load, disp_val,
                    output busy, ovf, anode, seg_out);
`endif
endinterface

// File: rtl/ssd_mux_display.sv
// ssd_mux_display
//   N-digit multiplexed seven-segment driver. A load strobe captures a binary
//   value, a sequential double-dabble converts it to BCD (one bit per cycle),
//   and the result is copied atomically into the display registers. A slot
//   counter scans the digits with one-hot active-low anodes, least significant
//   digit first, with leading-zero blanking and dash display on overflow.
//   Optional: define SSD_BRIGHTNESS_EN to add bus.bright[3:0] anode duty control.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active-high
//     bus  ssd_mux_display_if.slave (en, load, disp_val, busy, ovf, anode, seg_out)
module ssd_mux_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    ssd_mux_display_if.slave bus
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int ITER_W = $clog2(VAL_W + 1);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(pow10(NUM_DIGITS) - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nx;
    logic [VAL_W-1:0]    cap_val;
    logic [VAL_W-1:0]    shreg;
    logic [BCD_W-1:0]    bcd_scr;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_disp;
    logic                ovf_disp;
    logic                busy_r;
    logic [ITER_W-1:0]   iter;

    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic [NUM_DIGITS-1:0] anode_r, anode_nx;
    logic [6:0]            seg_r, seg_nx;
    logic [BCD_W-1:0]      shifted;
    logic                  blank;
    logic                  anode_lit;

    // Scratch BCD holds only NUM_DIGITS digits; carries out of the top nibble
    // are dropped, which only affects values that are flagged ovf anyway.
    always_comb begin
        bcd_adj = bcd_scr;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_scr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_scr[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.load) state_nx = SHIFT;
            SHIFT:   if (iter == ITER_W'(VAL_W - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cap_val  <= '0;
            shreg    <= '0;
            bcd_scr  <= '0;
            bcd_disp <= '0;
            ovf_disp <= 1'b0;
            busy_r   <= 1'b0;
            iter     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        cap_val <= bus.disp_val;
                        shreg   <= bus.disp_val;
                        bcd_scr <= '0;
                        iter    <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd_scr, shreg} <= {bcd_adj, shreg} << 1;
                    iter             <= iter + ITER_W'(1);
                end
                DONE: begin
                    bcd_disp <= bcd_scr;
                    ovf_disp <= (cap_val > MAX_VAL);
                    busy_r   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Digit under the scan pointer; it is blanked when it and all higher
    // digits are zero, except digit 0.
    always_comb begin
        shifted = bcd_disp >> (4 * dig_idx);
        blank   = (dig_idx != '0) && (shifted == '0);
        seg_nx  = 7'h7F;
        if (ovf_disp)
            seg_nx = 7'b0111111;
        else if (!blank) begin
            case (shifted[3:0])
                4'd0:    seg_nx = 7'b1000000;
                4'd1:    seg_nx = 7'b1111001;
                4'd2:    seg_nx = 7'b0100100;
                4'd3:    seg_nx = 7'b0110000;
                4'd4:    seg_nx = 7'b0011001;
                4'd5:    seg_nx = 7'b0010010;
                4'd6:    seg_nx = 7'b0000010;
                4'd7:    seg_nx = 7'b1111000;
                4'd8:    seg_nx = 7'b0000000;
                4'd9:    seg_nx = 7'b0010000;
                default: seg_nx = 7'h7F;
            endcase
        end
    end

    always_comb begin
`ifdef SSD_BRIGHTNESS_EN
        anode_lit = (32'(slot_cnt) <
                     (((32'(bus.bright) + 32'd1) * 32'(REFRESH_DIV)) / 32'd16));
`else
        anode_lit = 1'b1;
`endif
        anode_nx = anode_lit ? ~(NUM_DIGITS'(1) << dig_idx) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            anode_r  <= '1;
            seg_r    <= 7'h7F;
        end else if (!bus.en) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            anode_r  <= '1;
            seg_r    <= 7'h7F;
        end else begin
            anode_r <= anode_nx;
            seg_r   <= seg_nx;
            if (slot_cnt == SLOT_W'(REFRESH_DIV - 1)) begin
                slot_cnt <= '0;
                dig_idx  <= (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.ovf     = ovf_disp;
    assign bus.anode   = anode_r;
    assign bus.seg_out = seg_r;

endmodule

// File: tb/tb_ssd_mux_display.sv
// tb_ssd_mux_display
//   Self-checking bench for ssd_mux_display with NUM_DIGITS=4, VAL_W=14,
//   REFRESH_DIV=4: table of fixed values with hand-derived segment patterns,
//   corner-case sequences, and random values checked against a decimal model.
module tb_ssd_mux_display;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ssd_mux_display_if #(.NUM_DIGITS(4), .VAL_W(14)) bus ();

    ssd_mux_display #(
        .NUM_DIGITS (4),
        .VAL_W      (14),
        .REFRESH_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0]     val;
        logic            ovf;
        logic [3:0][6:0] segs;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][6:0] model(input int unsigned v);
        logic [6:0]      code [10];
        logic [3:0][6:0] r;
        int unsigned     p;
        code = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999)
                r[i] = 7'h3F;
            else if (i > 0 && v < p)
                r[i] = 7'h7F;
            else
                r[i] = code[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic do_load(input logic [13:0] v, input logic eovf, input string nm);
        int cyc;
        @(negedge clk);
        bus.disp_val = v;
        bus.load     = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
            bus.load = 1'b0;
        end while (bus.busy && cyc < 40);
        chk({nm, ".latency"}, 32'(cyc), 32'd16);
        chk({nm, ".ovf"}, 32'(bus.ovf), 32'(eovf));
    endtask

    task automatic scan_test(input logic [3:0][6:0] exp, input int ndark, input string nm);
        logic [3:0] ea;
        int         d;
        @(negedge clk);
        bus.en = 1'b0;
        for (int k = 0; k < ndark; k++) begin
            @(posedge clk);
            #1;
            chk({nm, ".dark_an"}, 32'(bus.anode), 32'hF);
            chk({nm, ".dark_seg"}, 32'(bus.seg_out), 32'h7F);
        end
        @(negedge clk);
        bus.en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            d  = k / 4;
            ea = ~(4'b0001 << d);
            chk({nm, ".anode"}, 32'(bus.anode), 32'(ea));
            chk({nm, ".seg"}, 32'(bus.seg_out), 32'(exp[d]));
        end
    endtask

    initial begin
        int          cyc;
        logic [13:0] rv;

        n_checks = 0;
        n_fail   = 0;

        tbl[0]  = '{14'd1234,  1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        tbl[1]  = '{14'd7,     1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
        tbl[2]  = '{14'd0,     1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tbl[3]  = '{14'd10000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tbl[4]  = '{14'd42,    1'b0, {7'h7F, 7'h7F, 7'h19, 7'h24}};
        tbl[5]  = '{14'd9999,  1'b0, {7'h10, 7'h10, 7'h10, 7'h10}};
        tbl[6]  = '{14'd100,   1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}};
        tbl[7]  = '{14'd16383, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tbl[8]  = '{14'd1000,  1'b0, {7'h79, 7'h40, 7'h40, 7'h40}};
        tbl[9]  = '{14'd10,    1'b0, {7'h7F, 7'h7F, 7'h79, 7'h40}};
        tbl[10] = '{14'd8056,  1'b0, {7'h00, 7'h40, 7'h12, 7'h02}};

        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.disp_val = '0;
`ifdef SSD_BRIGHTNESS_EN
        bus.bright   = 4'hF;
`endif
        #3;
        chk("reset.anode", 32'(bus.anode), 32'hF);
        chk("reset.seg", 32'(bus.seg_out), 32'h7F);
        chk("reset.busy", 32'(bus.busy), 32'h0);
        chk("reset.ovf", 32'(bus.ovf), 32'h0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_load(tbl[i].val, tbl[i].ovf, $sformatf("tbl%0d", i));
            scan_test(tbl[i].segs, 1, $sformatf("tbl%0d", i));
        end

        // load while busy is dropped, not queued
        @(negedge clk);
        bus.disp_val = 14'd55;
        bus.load     = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.disp_val = 14'd9999;
        bus.load     = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        chk("ignore.busy_mid", 32'(bus.busy), 32'h1);
        cyc = 6;
        while (bus.busy && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("ignore.latency", 32'(cyc), 32'd16);
        @(posedge clk);
        #1;
        chk("ignore.no_queue", 32'(bus.busy), 32'h0);
        scan_test({7'h7F, 7'h7F, 7'h12, 7'h12}, 1, "ignore");

        // en low for 10 cycles part-way through a slot
        do_load(14'd1234, 1'b0, "enoff");
        repeat (6) @(posedge clk);
        scan_test({7'h79, 7'h24, 7'h30, 7'h19}, 10, "enoff");

        // asynchronous reset mid-scan and mid-conversion, ovf previously set
        do_load(14'd16383, 1'b1, "prerst");
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.disp_val = 14'd1234;
        bus.load     = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst.anode", 32'(bus.anode), 32'hF);
        chk("midrst.seg", 32'(bus.seg_out), 32'h7F);
        chk("midrst.busy", 32'(bus.busy), 32'h0);
        chk("midrst.ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst.busy_after", 32'(bus.busy), 32'h0);
        scan_test({7'h7F, 7'h7F, 7'h7F, 7'h40}, 1, "midrst");

        for (int i = 0; i < 16; i++) begin
            rv = 14'($urandom_range(0, 16383) >> $urandom_range(0, 13));
            do_load(rv, (rv > 14'd9999), $sformatf("rnd%0d_%0d", i, rv));
            scan_test(model(32'(rv)), 1 + (i % 3), $sformatf("rnd%0d_%0d", i, rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
